arp_query_arbiter: RTL and testbench

// Shares the single query port of the ARP cache between PORTS requesters (IP TX path, UDP, mgmt).

---
 rtl/arp_query_arbiter.sv | 132 +++++++++++++
 tb/tb_arp_query_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_query_arbiter.sv
// Round-robin arbiter sharing the single ARP cache query port between PORTS requesters.
// One query in flight; a watchdog turns a silent cache into an error reply and drains the late answer.
module arp_query_arbiter #(
    parameter int PORTS   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PORTS-1:0]   s_query_request_valid,
    output logic [PORTS-1:0]   s_query_request_ready,
    input  logic [PORTS*32-1:0] s_query_request_ip,
    output logic [PORTS-1:0]   s_query_response_valid,
    input  logic [PORTS-1:0]   s_query_response_ready,
    output logic               s_query_response_error,
    output logic [47:0]        s_query_response_mac,
    output logic               m_query_request_valid,
    input  logic               m_query_request_ready,
    output logic [31:0]        m_query_request_ip,
    input  logic               m_query_response_valid,
    output logic               m_query_response_ready,
    input  logic               m_query_response_error,
    input  logic [47:0]        m_query_response_mac
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    // Valid/ready: a transfer happens on a rising edge where both are high; valid never waits on ready.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   rr_ptr, grant, sel, scan_idx;
    logic            any_valid;
    logic [31:0]     sel_ip;
    logic [TW-1:0]   timer;
    logic            drain;
    logic [31:0]     ip_q;
    logic            err_q;
    logic [47:0]     mac_q;
    logic            req_fire, resp_fire, timeout_hit;

    // First valid requester at or after rr_ptr, wrapping; lowest offset wins.
    always_comb begin
        sel       = '0;
        scan_idx  = '0;
        any_valid = 1'b0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            scan_idx = PW'((int'(rr_ptr) + k) % PORTS);
            if (s_query_request_valid[scan_idx]) begin
                sel       = scan_idx;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ip = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (PW'(i) == sel) sel_ip = s_query_request_ip[32*i +: 32];
        end
    end

    assign req_fire    = (state == ST_IDLE) && any_valid;
    assign resp_fire   = (state == ST_RESP) && s_query_response_ready[grant];
    assign timeout_hit = (TIMEOUT != 0) && (timer == TIMER_LAST);

    assign s_query_request_ready  = req_fire ? (PORTS'(1) << sel) : '0;
    assign s_query_response_valid = (state == ST_RESP) ? (PORTS'(1) << grant) : '0;
    assign s_query_response_error = err_q;
    assign s_query_response_mac   = mac_q;
    assign m_query_request_valid  = (state == ST_REQ);
    assign m_query_request_ip     = ip_q;
    assign m_query_response_ready = (state == ST_WAIT) || (state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (any_valid) state_next = ST_REQ;
            ST_REQ:   if (m_query_request_ready) state_next = ST_WAIT;
            ST_WAIT:  if (m_query_response_valid || timeout_hit) state_next = ST_RESP;
            ST_RESP:  if (resp_fire) state_next = drain ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (m_query_response_valid) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            grant  <= '0;
            ip_q   <= '0;
            err_q  <= 1'b0;
            mac_q  <= '0;
            timer  <= '0;
            drain  <= 1'b0;
        end else begin
            if (req_fire) begin
                ip_q  <= sel_ip;
                grant <= sel;
            end
            if (state == ST_REQ && m_query_request_ready) timer <= '0;
            if (state == ST_WAIT) begin
                if (m_query_response_valid) begin
                    err_q <= m_query_response_error;
                    mac_q <= m_query_response_mac;
                end else if (timeout_hit) begin
                    // The cache still owes a reply; it is swallowed in DRAIN before the next grant.
                    err_q <= 1'b1;
                    mac_q <= '0;
                    drain <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
            if (resp_fire) rr_ptr <= (grant == PW'(PORTS - 1)) ? '0 : grant + 1'b1;
            if (state == ST_DRAIN && m_query_response_valid) drain <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arp_query_arbiter.sv
// Directed bench for arp_query_arbiter: transaction-level model plus cycle-exact literal checks.
module tb_arp_query_arbiter;

    localparam int PORTS   = 4;
    localparam int TIMEOUT = 16;
    localparam int EW      = 54;  // {drain, err, port[3:0], mac[47:0]}

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PORTS-1:0]   s_query_request_valid = '0;
    logic [PORTS-1:0]   s_query_request_ready;
    logic [PORTS*32-1:0] s_query_request_ip = {32'h0A000003, 32'hC0A80102, 32'h0A000001, 32'h0A000000};
    logic [PORTS-1:0]   s_query_response_valid;
    logic [PORTS-1:0]   s_query_response_ready = '0;
    logic               s_query_response_error;
    logic [47:0]        s_query_response_mac;
    logic               m_query_request_valid;
    logic               m_query_request_ready = 1'b0;
    logic [31:0]        m_query_request_ip;
    logic               m_query_response_valid = 1'b0;
    logic               m_query_response_ready;
    logic               m_query_response_error = 1'b0;
    logic [47:0]        m_query_response_mac = '0;

    arp_query_arbiter #(.PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_query_request_valid  (s_query_request_valid),
        .s_query_request_ready  (s_query_request_ready),
        .s_query_request_ip     (s_query_request_ip),
        .s_query_response_valid (s_query_response_valid),
        .s_query_response_ready (s_query_response_ready),
        .s_query_response_error (s_query_response_error),
        .s_query_response_mac   (s_query_response_mac),
        .m_query_request_valid  (m_query_request_valid),
        .m_query_request_ready  (m_query_request_ready),
        .m_query_request_ip     (m_query_request_ip),
        .m_query_response_valid (m_query_response_valid),
        .m_query_response_ready (m_query_response_ready),
        .m_query_response_error (m_query_response_error),
        .m_query_response_mac   (m_query_response_mac)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1, "global timeout");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- model / scoreboard ----------------
    typedef enum {M_FREE, M_BUSY, M_DRAINING} mphase_t;
    mphase_t          phase = M_FREE;
    int               model_rr = 0;
    logic [31:0]      model_ip = '0;
    logic [EW-1:0]    exp_q[$];
    int               grant_log[$];
    int               resp_count = 0;

    function automatic int next_requester(input logic [PORTS-1:0] v, input int start);
        for (int k = 0; k < PORTS; k++) begin
            int p;
            p = (start + k) % PORTS;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [31:0] ip_of(input int p);
        return s_query_request_ip[32*p +: 32];
    endfunction

    task automatic expect_resp(input int port, input logic err, input logic [47:0] mac, input logic drn);
        exp_q.push_back({drn, err, 4'(port), mac});
    endtask

    always @(negedge clk) begin
        mphase_t        ph;
        int             s;
        int             gp;
        logic [PORTS-1:0] exp_ready;
        logic [EW-1:0]  e;
        if (rst) begin
            phase    = M_FREE;
            model_rr = 0;
            exp_q.delete();
        end else begin
            ph = phase;
            s  = next_requester(s_query_request_valid, model_rr);
            exp_ready = (ph == M_FREE && s >= 0) ? (PORTS'(1) << s) : '0;
            check("req_ready", s_query_request_ready, exp_ready);
            if (ph != M_BUSY) begin
                check("m_req_valid_idle", m_query_request_valid, 0);
                check("s_resp_valid_idle", s_query_response_valid, 0);
            end
            if (ph == M_FREE) check("m_resp_ready_idle", m_query_response_ready, 0);
            if (ph == M_DRAINING) check("drain_m_ready", m_query_response_ready, 1);
            if (m_query_request_valid) check("m_req_ip", m_query_request_ip, model_ip);
            if (ph == M_FREE && s >= 0) begin
                phase    = M_BUSY;
                model_ip = ip_of(s);
                grant_log.push_back(s);
            end
            if (ph == M_BUSY && s_query_response_valid != 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", s_query_response_valid, 0);
                end else begin
                    e  = exp_q[0];
                    gp = int'(e[51:48]);
                    check("resp_valid", s_query_response_valid, PORTS'(1) << gp);
                    check("resp_err", s_query_response_error, e[52]);
                    check("resp_mac", s_query_response_mac, e[47:0]);
                    if (s_query_response_ready[gp]) begin
                        void'(exp_q.pop_front());
                        model_rr = (gp + 1) % PORTS;
                        phase    = e[53] ? M_DRAINING : M_FREE;
                        resp_count++;
                    end
                end
            end
            if (ph == M_DRAINING && m_query_response_valid && m_query_response_ready) phase = M_FREE;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req_grant(input string name);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (m_query_request_valid) return;
        end
        bound_fail(name);
    endtask

    task automatic wait_resp(input string name);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (s_query_response_valid != 0) return;
        end
        bound_fail(name);
    endtask

    // ---------------- directed tests ----------------
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int base;
        int rc0;
        logic distinct;
        do_reset();
        @(negedge clk);
        check("reset_req_ready", s_query_request_ready, 0);
        check("reset_resp_valid", s_query_response_valid, 0);
        check("reset_m_valid", m_query_request_valid, 0);
        check("reset_m_resp_ready", m_query_response_ready, 0);
        check("reset_ip", m_query_request_ip, 0);
        check("reset_mac", s_query_response_mac, 0);
        check("reset_err", s_query_response_error, 0);

        // Single query, port 2, cache reply already waiting: four cycles end to end.
        tick();
        expect_resp(2, 1'b0, 48'h001122334455, 1'b0);
        m_query_request_ready  = 1'b1;
        s_query_response_ready = 4'hF;
        m_query_response_valid = 1'b1;
        m_query_response_error = 1'b0;
        m_query_response_mac   = 48'h001122334455;
        s_query_request_valid  = 4'b0100;
        @(negedge clk);
        check("t1_ready", s_query_request_ready, 4'b0100);
        tick();
        s_query_request_valid = '0;
        @(negedge clk);
        check("t1_m_valid", m_query_request_valid, 1);
        check("t1_ip", m_query_request_ip, 32'hC0A80102);
        tick();
        @(negedge clk);
        check("t1_wait_ready", m_query_response_ready, 1);
        check("t1_no_resp_yet", s_query_response_valid, 0);
        tick();
        m_query_response_valid = 1'b0;
        @(negedge clk);
        check("t1_resp_valid", s_query_response_valid, 4'b0100);
        check("t1_resp_mac", s_query_response_mac, 48'h001122334455);
        check("t1_resp_err", s_query_response_error, 0);
        tick();
        @(negedge clk);
        check("t1_done", s_query_response_valid, 0);

        // All four requesting from reset: 0,1,2,3,0.
        tick();
        do_reset();
        m_query_response_valid = 1'b1;
        m_query_response_mac   = 48'h0A0B0C0D0E0F;
        for (int i = 0; i < 5; i++) expect_resp(exp_order[i], 1'b0, 48'h0A0B0C0D0E0F, 1'b0);
        base = grant_log.size();
        rc0  = resp_count;
        s_query_request_valid = 4'hF;
        for (int i = 0; i < 200 && resp_count < rc0 + 5; i++) tick();
        if (resp_count < rc0 + 5) bound_fail("t2_responses");
        s_query_request_valid  = '0;
        m_query_response_valid = 1'b0;
        check("t2_grant_count", grant_log.size() - base, 5);
        if (grant_log.size() - base >= 5) begin
            for (int i = 0; i < 5; i++) check("t2_order", grant_log[base+i], exp_order[i]);
            for (int i = base; i + 3 < grant_log.size(); i++) begin
                distinct = 1'b1;
                for (int a = 0; a < 4; a++)
                    for (int b = a + 1; b < 4; b++)
                        if (grant_log[i+a] == grant_log[i+b]) distinct = 1'b0;
                check("t2_window", distinct, 1);
            end
        end
        tick();

        // Cache miss, port 1 holds off its response ready.
        expect_resp(1, 1'b1, 48'h0, 1'b0);
        s_query_response_ready = 4'b1101;
        m_query_response_valid = 1'b1;
        m_query_response_error = 1'b1;
        m_query_response_mac   = 48'h0;
        s_query_request_valid  = 4'b0010;
        wait_req_grant("t3_grant");
        s_query_request_valid = '0;
        wait_resp("t3_resp");
        m_query_response_valid = 1'b0;
        m_query_response_error = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_hold_valid", s_query_response_valid, 4'b0010);
            check("t3_hold_err", s_query_response_error, 1);
            tick();
        end
        s_query_response_ready = 4'hF;
        tick();
        @(negedge clk);
        check("t3_released", s_query_response_valid, 0);
        tick();

        // Silent cache: watchdog reply on the 17th cycle after accept, late reply drained at 40.
        expect_resp(3, 1'b1, 48'h0, 1'b1);
        s_query_request_valid = 4'b1000;
        wait_req_grant("t4_grant");
        s_query_request_valid = '0;
        tick();  // accept edge: REQ with m_query_request_ready high
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n == 16) begin
                check("t4_n16_no_resp", s_query_response_valid, 0);
                check("t4_n16_m_ready", m_query_response_ready, 1);
            end
            if (n == 17) begin
                check("t4_n17_valid", s_query_response_valid, 4'b1000);
                check("t4_n17_err", s_query_response_error, 1);
                check("t4_n17_mac", s_query_response_mac, 0);
            end
        end
        tick();  // accept edge + 17: response taken, now draining
        s_query_request_valid = 4'b0001;
        @(negedge clk);
        check("t4_drain_no_grant", s_query_request_ready, 0);
        check("t4_drain_m_ready", m_query_response_ready, 1);
        repeat (23) tick();  // accept edge + 40
        m_query_response_valid = 1'b1;
        m_query_response_mac   = 48'hDEADBEEF0BAD;
        @(negedge clk);
        check("t4_late_no_grant", s_query_request_ready, 0);
        tick();
        m_query_response_valid = 1'b0;
        @(negedge clk);
        check("t4_grant_after_drain", s_query_request_ready, 4'b0001);
        expect_resp(0, 1'b0, 48'h665544332211, 1'b0);
        tick();
        s_query_request_valid  = '0;
        m_query_response_valid = 1'b1;
        m_query_response_mac   = 48'h665544332211;
        wait_resp("t4_next_resp");
        m_query_response_valid = 1'b0;
        tick();
        tick();

        // Backpressure on both sides: ip, error and mac stay put.
        m_query_request_ready  = 1'b0;
        s_query_response_ready = '0;
        expect_resp(2, 1'b0, 48'h5A5A01020304, 1'b0);
        s_query_request_valid = 4'b0100;
        wait_req_grant("t5_grant");
        s_query_request_valid = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_req_valid", m_query_request_valid, 1);
            check("t5_req_ip", m_query_request_ip, 32'hC0A80102);
            tick();
        end
        m_query_request_ready  = 1'b1;
        m_query_response_valid = 1'b1;
        m_query_response_mac   = 48'h5A5A01020304;
        wait_resp("t5_resp");
        m_query_response_valid = 1'b0;
        m_query_response_mac   = 48'hFFFFFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", s_query_response_valid, 4'b0100);
            check("t5_hold_mac", s_query_response_mac, 48'h5A5A01020304);
            check("t5_hold_err", s_query_response_error, 0);
            tick();
        end
        s_query_response_ready = 4'hF;
        tick();
        @(negedge clk);
        check("t5_released", s_query_response_valid, 0);
        tick();

        // Reset while waiting on the cache.
        s_query_request_valid = 4'b1000;
        wait_req_grant("t6_grant");
        s_query_request_valid = '0;
        tick();
        @(negedge clk);
        check("t6_in_wait", m_query_response_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_req_ready", s_query_request_ready, 0);
        check("t6_resp_valid", s_query_response_valid, 0);
        check("t6_m_valid", m_query_request_valid, 0);
        check("t6_m_resp_ready", m_query_response_ready, 0);
        check("t6_ip", m_query_request_ip, 0);
        check("t6_mac", s_query_response_mac, 0);
        check("t6_err", s_query_response_error, 0);
        tick();
        expect_resp(0, 1'b0, 48'h123456789ABC, 1'b0);
        s_query_request_valid = 4'hF;
        @(negedge clk);
        check("t6_port0_first", s_query_request_ready, 4'b0001);
        tick();
        s_query_request_valid  = '0;
        m_query_response_valid = 1'b1;
        m_query_response_mac   = 48'h123456789ABC;
        wait_resp("t6_resp");
        m_query_response_valid = 1'b0;
        tick();
        tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
